// File: rtl/dram_arb_pkg.sv
// Shared definitions for the LUTRAM arbiter slice.
//   ADDR_W / DEPTH : geometry of the 128x1 distributed RAM
//   state_t        : sequencer states (clear sweep, normal service)
//   ram_req_t      : one access on the single write/read port
package dram_arb_pkg;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 128;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic              data;
  } ram_req_t;
endpackage

// File: rtl/RAM128X1D.sv
// Behavioural stand-in for the 128x1 dual-port distributed RAM primitive.
// In the vendor flow the library cell of the same name replaces this file.
//   WCLK/WE/A/D : synchronous write port; SPO = mem[A] (async)
//   DPRA/DPO    : independent async read port
module RAM128X1D #(
  parameter logic [127:0] INIT = 128'h0
) (
  output wire       DPO,
  output wire       SPO,
  input  wire [6:0] A,
  input  wire [6:0] DPRA,
  input  wire       D,
  input  wire       WCLK,
  input  wire       WE
);
  // Contents come from the configuration image, not from any reset.
  logic [127:0] mem = INIT;

  always_ff @(posedge WCLK)
    if (WE) mem[A] <= D;

  assign SPO = mem[A];
  assign DPO = mem[DPRA];
endmodule

// File: rtl/rr_arb2.sv
// Two-input round-robin grant.
//   valid[1:0] : requests (already qualified by the caller)
//   advance    : a grant was taken this cycle; remember who won
//   grant[1:0] : one-hot (or zero) grant, combinational
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);
  // Client that won the most recent grant; 1 after reset so client 0 wins
  // the first tie.
  logic rr_last;

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr_last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)       rr_last <= 1'b1;
    else if (advance) rr_last <= grant[1];
endmodule

// File: rtl/dram_arbiter.sv
// Round-robin front end for one 128x1 LUTRAM.
//   reqN_* / rspN_* : two clients; ready is combinational, response is a
//                     one-cycle pulse carrying the word's pre-access value
//   mon_addr/data   : registered read of the second (read-only) port
//   busy            : power-on clear sweep in progress
module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter bit           CLEAR_ON_RESET = 1'b1,
  parameter logic [127:0] INIT           = 128'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic              req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic              req1_data,
  output logic              rsp0_valid,
  output logic              rsp0_data,
  output logic              rsp1_valid,
  output logic              rsp1_data,
  input  logic [ADDR_W-1:0] mon_addr,
  output logic              mon_data,
  output logic              busy
);
  localparam state_t RST_ST = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt;
  logic [1:0]        grant;
  logic              run;
  ram_req_t          port;
  logic              spo, dpo;

  assign run  = (state == ST_RUN);
  assign busy = (state == ST_CLEAR);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   ({req1_valid, req0_valid} & {2{run}}),
    .advance (|grant),
    .grant   (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= RST_ST;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    if (state == ST_CLEAR && clr_cnt == ADDR_W'(DEPTH - 1)) state_nxt = ST_RUN;
  end

  // Counter wraps to 0 on the last clear write, ready for the next reset.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                 clr_cnt <= '0;
    else if (state == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;

  // Single RAM port: clear sweep, then whichever client holds the grant.
  always_comb begin
    port = '0;
    if (!run)          port = '{we: 1'b1, addr: clr_cnt, data: 1'b0};
    else if (grant[0]) port = '{we: req0_we, addr: req0_addr, data: req0_data};
    else if (grant[1]) port = '{we: req1_we, addr: req1_addr, data: req1_data};
  end

  RAM128X1D #(.INIT(INIT)) u_ram (
    .DPO  (dpo),
    .SPO  (spo),
    .A    (port.addr),
    .DPRA (mon_addr),
    .D    (port.data),
    .WCLK (clk),
    .WE   (port.we)
  );

  // SPO is sampled on the accepting edge, before the write lands, so a
  // write returns the old word too.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_data  <= 1'b0;
      rsp1_data  <= 1'b0;
      mon_data   <= 1'b0;
    end else begin
      rsp0_valid <= grant[0];
      rsp1_valid <= grant[1];
      if (grant[0]) rsp0_data <= spo;
      if (grant[1]) rsp1_data <= spo;
      mon_data <= dpo;
    end
endmodule

// File: tb/tb_dram_arbiter.sv
module tb_dram_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // DUT A: clear on reset, RAM preloaded with all ones
  logic       v0, v1, we0, we1, d0, d1;
  logic [6:0] a0, a1, ma;
  logic       r0, r1, s0v, s1v, s0d, s1d, md, busy;

  // DUT B: no clear, INIT = 2'b10
  logic       bv0, bwe0, bd0, bv1, bwe1, bd1;
  logic [6:0] ba0, ba1, bma;
  logic       br0, br1, bs0v, bs1v, bs0d, bs1d, bmd, bbusy;

  dram_arbiter #(.CLEAR_ON_RESET(1'b1), .INIT({128{1'b1}})) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_ready(r0), .req0_we(we0), .req0_addr(a0), .req0_data(d0),
    .req1_valid(v1), .req1_ready(r1), .req1_we(we1), .req1_addr(a1), .req1_data(d1),
    .rsp0_valid(s0v), .rsp0_data(s0d), .rsp1_valid(s1v), .rsp1_data(s1d),
    .mon_addr(ma), .mon_data(md), .busy(busy)
  );

  dram_arbiter #(.CLEAR_ON_RESET(1'b0), .INIT(128'b10)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(bv0), .req0_ready(br0), .req0_we(bwe0), .req0_addr(ba0), .req0_data(bd0),
    .req1_valid(bv1), .req1_ready(br1), .req1_we(bwe1), .req1_addr(ba1), .req1_data(bd1),
    .rsp0_valid(bs0v), .rsp0_data(bs0d), .rsp1_valid(bs1v), .rsp1_data(bs1d),
    .mon_addr(bma), .mon_data(bmd), .busy(bbusy)
  );

  int n_vec = 0;
  int n_err = 0;
  bit q0[$], q1[$], qb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: response with no expected entry (t=%0t)", nm, $time);
  endtask

  // Scoreboard monitor: compares every response pulse against the queue.
  always @(posedge clk) begin
    #1;
    if (s0v) begin
      if (q0.size() == 0) unexpected("rsp0");
      else chk("rsp0_data", s0d, q0.pop_front());
    end
    if (s1v) begin
      if (q1.size() == 0) unexpected("rsp1");
      else chk("rsp1_data", s1d, q1.pop_front());
    end
    if (bs0v) begin
      if (qb.size() == 0) unexpected("b_rsp0");
      else chk("b_rsp0_data", bs0d, qb.pop_front());
    end
    if (bs1v) unexpected("b_rsp1");
  end

  // One DUT A cycle, called at a negedge; returns at the next negedge.
  task automatic cyc(input logic iv0, iwe0, input logic [6:0] ia0, input logic id0, ie0,
                     input logic iv1, iwe1, input logic [6:0] ia1, input logic id1, ie1,
                     input logic er0, er1, ebusy);
    v0 = iv0; we0 = iwe0; a0 = ia0; d0 = id0;
    v1 = iv1; we1 = iwe1; a1 = ia1; d1 = id1;
    #1;
    chk("ready0", r0, er0);
    chk("ready1", r1, er1);
    chk("busy", busy, ebusy);
    if (r0 && v0) q0.push_back(ie0);
    if (r1 && v1) q1.push_back(ie1);
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(0, 0, 7'd0, 0, 0, 0, 0, 7'd0, 0, 0, 0, 0, 0);
  endtask

  task automatic stall();
    cyc(1, 0, 7'd0, 0, 0, 0, 0, 7'd0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    {v0, v1, we0, we1, d0, d1} = '0; a0 = '0; a1 = '0; ma = '0;
    {bv0, bwe0, bd0, bv1, bwe1, bd1} = '0; ba0 = '0; ba1 = '0; bma = 7'd1;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready0", r0, 0);
    chk("rst_ready1", r1, 0);
    chk("rst_rsp0_valid", s0v, 0);
    chk("rst_rsp1_valid", s1v, 0);
    chk("rst_rsp0_data", s0d, 0);
    chk("rst_rsp1_data", s1d, 0);
    chk("rst_mon_data", md, 0);
    chk("rst_busy", busy, 1);
    chk("b_rst_busy", bbusy, 0);
    chk("b_rst_mon", bmd, 0);
    chk("b_rst_ready1", br1, 0);
    chk("b_rst_rsp1_data", bs1d, 0);

    // Partial clear, then reset again at clr_cnt = 60
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) stall();
    rst_n = 1'b0;
    #1;
    chk("midclr_busy", busy, 1);
    chk("midclr_ready0", r0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full 128-cycle clear with client 0 stalled throughout
    repeat (128) stall();
    // Cycle 129: first grant, addr 0 now cleared
    cyc(1, 0, 7'd0, 0, 0, 0, 0, 7'd0, 0, 0, 1, 0, 0);
    idle();

    // Monitor sweep: INIT ones must all be cleared
    for (int i = 0; i < 128; i++) begin
      ma = 7'(i);
      @(negedge clk);
      chk("mon_sweep", md, 0);
    end

    // Client 0 write addr 5 = 1, then read it back
    cyc(1, 1, 7'd5, 1, 0, 0, 0, 7'd0, 0, 0, 1, 0, 0);
    cyc(1, 0, 7'd5, 0, 1, 0, 0, 7'd0, 0, 0, 1, 0, 0);
    idle();

    // Monitor addr 9 while client 1 writes 1 there
    ma = 7'd9;
    idle();
    cyc(0, 0, 7'd0, 0, 0, 1, 1, 7'd9, 1, 0, 0, 1, 0);
    chk("mon_write_edge", md, 0);
    idle();
    chk("mon_after_write", md, 1);

    // Client 1 writes addr 4 = 1 (rr_last -> 1)
    cyc(0, 0, 7'd0, 0, 0, 1, 1, 7'd4, 1, 0, 0, 1, 0);

    // Both clients continuously: client 0 reads 3 (0), client 1 reads 4 (1)
    cyc(1, 0, 7'd3, 0, 0, 1, 0, 7'd4, 0, 1, 1, 0, 0);
    cyc(1, 0, 7'd3, 0, 0, 1, 0, 7'd4, 0, 1, 0, 1, 0);
    cyc(1, 0, 7'd3, 0, 0, 1, 0, 7'd4, 0, 1, 1, 0, 0);
    cyc(1, 0, 7'd3, 0, 0, 1, 0, 7'd4, 0, 1, 0, 1, 0);
    idle();

    // DUT B: no clear, INIT bit 1 set
    chk("b_mon_addr1", bmd, 1);
    bv0 = 1'b1; ba0 = 7'd1;
    #1;
    chk("b_ready0_a1", br0, 1);
    if (br0) qb.push_back(1'b1);
    @(negedge clk);
    ba0 = 7'd0;
    #1;
    chk("b_ready0_a0", br0, 1);
    if (br0) qb.push_back(1'b0);
    @(negedge clk);
    bv0 = 1'b0;

    repeat (3) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("qb_drained", qb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dram_arbiter.md
# dram_arbiter

Two-requester round-robin front end for one RAM128X1D distributed-RAM primitive (128x1, one sync write port, two async read ports), with a power-on clear sequencer and a registered monitor read port. It sits between fabric clients (switch/UART-driven test logic) and the LUTRAM, serialising all accesses onto the single A/D/WE port and exposing DPRA/DPO as an independent read-only monitor.

## Interface

Parameters:
- CLEAR_ON_RESET, default 1: 1 = write 0 to all 128 words after reset before serving requests; 0 = serve immediately.
- INIT, default 128'b0: RAM128X1D INIT value (contents at configuration).

Ports (clock and reset: one clock; reset is asynchronous and active-low):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid / req1_valid  in  1  request pending from client 0 / 1.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- req0_we / req1_we  in  1  1 = write, 0 = read.
- req0_addr / req1_addr  in  7  word address.
- req0_data / req1_data  in  1  write data (ignored on read).
- rsp0_valid / rsp1_valid  out  1  one-cycle response pulse.
- rsp0_data / rsp1_data  out  1  word content before the access.
- mon_addr  in  7  monitor address (drives DPRA).
- mon_data  out  1  registered DPO.
- busy  out  1  high while clear sequence runs.

## Operation

- States: CLEAR, RUN. Reset enters CLEAR if CLEAR_ON_RESET=1, else RUN.
- CLEAR: 7-bit clr_cnt from 0; each cycle A=clr_cnt, D=0, WE=1; cnt increments. Write at cnt=127 is last; next state RUN, cnt wraps to 0. No ready asserted, requests stall (valid held by client).
- RUN: at most one grant per cycle. Only one valid: grant it. Both valid: grant client opposite to last granted (rr_last; reset value 1, so client 0 wins first tie). rr_last updates only on a grant.
- reqN_ready = state==RUN & grant==N; combinational from valids and rr_last. Accepted = valid & ready.
- Granted request drives A=addr, D=data, WE=we. No grant: WE=0, A=0.
- Response: cycle after acceptance, rspN_valid=1, rspN_data = SPO sampled at accepting edge (old contents, read-before-write for writes too).
- Monitor: mon_data <= DPO every edge in all states; write on same edge to same address yields old value.
- busy = (state==CLEAR).
- Reset mid-clear or mid-traffic: all state/outputs return to reset values immediately; in-flight response dropped; clear restarts at address 0. RAM contents not touched by rst_n itself.

## Timing

- Reset values: req*_ready 0, rsp*_valid 0, rsp*_data 0, mon_data 0, busy = CLEAR_ON_RESET, clr_cnt 0, rr_last 1.
- Clear: exactly 128 cycles after rst_n deassertion edge; first ready possible on cycle 129.
- Request-to-response latency 1 cycle; throughput 1 access/cycle total.
- Write visible to SPO/DPO after write edge; read accepted next cycle returns new value.
- Monitor latency 1 cycle; independent of arbitration.
- Back-to-back from both clients alternates 0,1,0,1; single client continuous gets every cycle.

## Structure

- Package dram_arb_pkg: ADDR_W=7, DEPTH=128, state typedef (ST_CLEAR, ST_RUN).
- Sub-module rr_arb2: 2-input round-robin grant with rr_last register, interface valid[1:0], grant[1:0], advance.
- Top instantiates RAM128X1D directly with INIT; clear mux and response registers in top.

## Test plan

- Reset with CLEAR_ON_RESET=1, INIT=128'hFFFF...: busy high 128 cycles, ready 0 throughout; afterwards mon sweep 0..127 returns all 0.
- Client 0 write addr 5 data 1, next cycle read addr 5: first rsp0_data=0, second rsp0_data=1.
- Both clients valid continuously, reads to addr 3 and 4: grants 0,1,0,1; each rsp on correct port 1 cycle later.
- Monitor addr 9 while client 1 writes 1 to addr 9: mon_data 0 on write edge, 1 on following edge.
- rst_n asserted at clear cnt 60: busy stays high, clear restarts at 0, 128 further cycles before ready.
- CLEAR_ON_RESET=0, INIT=128'b10: busy 0 from reset; client 0 read addr 1 -> rsp0_data=1, addr 0 -> 0.
